// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Front-panel push-button conditioner. Raw active-low key pins are
//   synchronised, debounced and presented as an active-high level, along with
//   registered one-cycle press, release and auto-repeat pulses.
//
//   Each button is handled by an independent button_channel instance.
//
// Ports
//   clk_clk        in   1          system clock
//   reset_reset    in   1          synchronous active-high reset
//   key_n          in   N_BUTTONS  raw button pins, active-low, asynchronous
//   repeat_en      in   N_BUTTONS  per-channel auto-repeat enable
//   buttons_level  out  N_BUTTONS  debounced level, 1 = pressed
//   press_pulse    out  N_BUTTONS  one-cycle pulse on press and each repeat
//   release_pulse  out  N_BUTTONS  one-cycle pulse on release
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// button_channel
//   One button: two-flop synchroniser, debounce counter, and a repeat FSM
//   (IDLE/DELAY/REPEAT). Every output is a flop.
//
// Ports
//   clk            in   1  clock
//   rst            in   1  synchronous active-high reset
//   key_n          in   1  raw pin, active-low
//   repeat_en      in   1  auto-repeat enable
//   level          out  1  debounced level
//   press_pulse    out  1  press / repeat pulse
//   release_pulse  out  1  release pulse
// ---------------------------------------------------------------------------
module button_channel #(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RD_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] RR_LAST = TMR_W'(REPEAT_RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [1:0]       sync_q;
    logic             sync;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_d;
    logic             press_d, release_d;
    logic             accept;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    // Flops reset to 1 so a released key looks released straight out of reset.
    assign sync = ~sync_q[1];

    always_comb begin
        db_cnt_d  = '0;
        level_d   = level;
        accept    = 1'b0;
        press_d   = 1'b0;
        release_d = 1'b0;
        state_d   = state_q;
        timer_d   = timer_q;

        // Debounce: any return to agreement clears the count.
        if (sync != level) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync;
                accept  = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (accept && sync) begin
                    state_d = DELAY;
                    timer_d = '0;
                    press_d = 1'b1;
                end
            end
            DELAY: begin
                if (!repeat_en) begin
                    timer_d = '0;
                end else if (timer_q == RD_LAST && level) begin
                    press_d = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            REPEAT: begin
                if (!repeat_en) begin
                    state_d = DELAY;
                    timer_d = '0;
                end else if (timer_q == RR_LAST) begin
                    press_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // A release wins over any repeat due on the same edge.
        if (accept && !sync) begin
            state_d   = IDLE;
            timer_d   = '0;
            press_d   = 1'b0;
            release_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= 2'b11;
            db_cnt_q      <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            state_q       <= IDLE;
            timer_q       <= '0;
        end else begin
            sync_q        <= {sync_q[0], key_n};
            db_cnt_q      <= db_cnt_d;
            level         <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
        end
    end

endmodule

module button_conditioner #(
    parameter int N_BUTTONS           = 2,
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [N_BUTTONS-1:0] key_n,
    input  logic [N_BUTTONS-1:0] repeat_en,
    output logic [N_BUTTONS-1:0] buttons_level,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
        ) u_ch (
            .clk          (clk_clk),
            .rst          (reset_reset),
            .key_n        (key_n[g]),
            .repeat_en    (repeat_en[g]),
            .level        (buttons_level[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g])
        );
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioner for the alarm-clock front panel. It takes the raw, active-low, asynchronous push-button pins, synchronises and debounces them, and drives the debounced level into the Qsys system's `buttons_external_connection_export` PIO input. It also produces one-cycle press, release and auto-repeat pulses, so holding a button fast-advances the time or alarm setting. Each button channel operates independently.

## Interface

Parameters:
- `N_BUTTONS`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY_CYCLES`, 25000000: hold time from press pulse to first repeat pulse (0.5 s). Must be ≥ 2.
- `REPEAT_RATE_CYCLES`, 5000000: period between later repeat pulses (0.1 s). Must be ≥ 2.

Ports:
- `clk_clk`, in, 1: system clock; single clock domain.
- `reset_reset`, in, 1: synchronous, active-high reset.
- `key_n`, in, N_BUTTONS: raw button pins, active-low, asynchronous.
- `repeat_en`, in, N_BUTTONS: per-channel auto-repeat enable; sampled every cycle.
- `buttons_level`, out, N_BUTTONS: debounced level, active-high (1 = pressed); connects to the PIO input.
- `press_pulse`, out, N_BUTTONS: one-cycle pulse on an accepted press and on each auto-repeat.
- `release_pulse`, out, N_BUTTONS: one-cycle pulse on an accepted release.

## Operation

- **Synchroniser:** two flops per channel on `key_n`. Both reset to 1 (released). The second stage is inverted to give `sync` (1 = pressed).
- **Debounce:** one counter per channel, width clog2(DEBOUNCE_CYCLES).
  - `sync == buttons_level`: counter ← 0.
  - Mismatch and counter < DEBOUNCE_CYCLES−1: counter ← counter+1.
  - Mismatch and counter == DEBOUNCE_CYCLES−1: `buttons_level` ← `sync`, counter ← 0.
  - Any bounce back to a match clears the counter, so a glitch shorter than DEBOUNCE_CYCLES never changes the level.
- **Pulses:** all outputs are registered. `press_pulse` goes high in the same cycle `buttons_level` first reads 1. `release_pulse` goes high in the same cycle `buttons_level` first reads 0.
- **Per-channel repeat FSM:** states IDLE, DELAY, REPEAT. The timer counts up to max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)−1.
  - IDLE → DELAY on an accepted press, timer ← 0. The only pulse is the press pulse.
  - DELAY: timer increments each cycle.
    - If timer == REPEAT_DELAY_CYCLES−1, the level is still 1 and `repeat_en` = 1: assert `press_pulse`, timer ← 0, go to REPEAT.
    - If `repeat_en` = 0: the timer is held at 0 and no pulse is produced.
  - REPEAT: timer increments. When timer == REPEAT_RATE_CYCLES−1: `press_pulse`, timer ← 0.
    - If `repeat_en` drops: go to DELAY with timer ← 0.
  - Any state: an accepted release forces IDLE and timer ← 0 in the same edge that clears the level. No press pulse is produced on that edge.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.

## Timing

- **Reset values:** `buttons_level` = 0, `press_pulse` = 0, `release_pulse` = 0, all FSMs IDLE, all counters 0, synchroniser flops 1.
- **Reset mid-operation:** all channels return to the reset state on the next edge, and no pulses are produced. A button still held after reset is re-accepted as a new press after the full debounce latency.
- **Latency:** if a new raw level is first captured at edge k and then held, `buttons_level` and the corresponding pulse update at edge k+DEBOUNCE_CYCLES+1.
- **Pulse schedule:** for a press pulse at edge P with the button held and `repeat_en` = 1, further `press_pulse` edges occur at P+REPEAT_DELAY_CYCLES, then every REPEAT_RATE_CYCLES after that.
- **Pulse width:** every pulse is exactly one cycle wide. `press_pulse` and `release_pulse` are never high together on the same channel.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.

1. **Clean press/release:** `key_n[0]` 1→0, captured at edge 10 and held → `buttons_level[0]`=1 and `press_pulse[0]` high for one cycle at edge 15. Release captured at edge 40 → level 0 and `release_pulse[0]` at edge 45.
2. **Bounce:** `key_n[0]` low for 3 cycles, high for 1, then low steady from edge 20 → no pulse before edge 25, exactly one `press_pulse` at edge 25.
3. **Auto-repeat:** hold with `repeat_en[0]`=1, press pulse at edge P → pulses at P+10, P+13, P+16. Release → `release_pulse` only, then no further press pulses.
4. **Repeat disabled:** same hold with `repeat_en[0]`=0 for 50 cycles → only the initial press pulse. Raising `repeat_en` while still held → next pulse 10 cycles later.
5. **Simultaneous channels:** both keys captured low at the same edge → `press_pulse`=2'b11 in one cycle. Releasing `key_n[1]` only → `release_pulse`=2'b10, while channel 0 repeats unaffected.
6. **Reset:** assert `reset_reset` mid-repeat with the key held → all outputs 0 on the next edge. Deassert with the key still held → a new press pulse 5 edges after the first post-reset capture.
